// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes and the issue FSM encoding.
package alu_pkg;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLT  = 4'd2;
  localparam logic [3:0] SLTU = 4'd3;
  localparam logic [3:0] XOR  = 4'd4;
  localparam logic [3:0] ORR  = 4'd5;
  localparam logic [3:0] AND  = 4'd6;
  localparam logic [3:0] SLL  = 4'd7;
  localparam logic [3:0] SRL  = 4'd8;
  localparam logic [3:0] SRA  = 4'd9;
  localparam logic [3:0] ADDU = 4'd10;
  localparam logic [3:0] SUBU = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       winner_o,
  output logic       any_valid_o
);

  always_comb begin
    any_valid_o = |valid_i;
    winner_o    = 1'b0;
    if (valid_i == 2'b11) begin
      winner_o = ~last_grant_i;
    end else if (valid_i[1]) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one external ALU between two requesters, one operation in flight.
// Optional grant counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [3:0]       r0_ctrl,
  input  logic [4:0]       r0_shamt,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [3:0]       r1_ctrl,
  input  logic [4:0]       r1_shamt,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [3:0]       alu_control,
  output logic [4:0]       alu_shamt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]      grant_cnt0,
  output logic [31:0]      grant_cnt1
`endif
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       alu_control_q, alu_control_d;
  logic [4:0]       alu_shamt_q, alu_shamt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             winner;
  logic             any_valid;
  logic             accept;
  logic             owner_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({r1_req_valid, r0_req_valid}),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_valid_o  (any_valid)
  );

  // Reset gates the grant so a requester never sees a handshake that the
  // reset edge would then discard.
  assign accept          = (state_q == IDLE) && any_valid && !reset;
  assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    alu_control_d = alu_control_q;
    alu_shamt_d   = alu_shamt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (winner) begin
            alu_control_d = r1_ctrl;
            alu_shamt_d   = r1_shamt;
            alu_a_d       = r1_a;
            alu_b_d       = r1_b;
          end else begin
            alu_control_d = r0_ctrl;
            alu_shamt_d   = r0_shamt;
            alu_a_d       = r0_a;
            alu_b_d       = r0_b;
          end
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d = alu_out;
        rsp_zero_d = (alu_out == '0);
        state_d    = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      alu_control_q <= '0;
      alu_shamt_q   <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      alu_control_q <= alu_control_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
    end
  end

  assign r0_req_ready = accept && !winner;
  assign r1_req_ready = accept && winner;
  assign r0_rsp_valid = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid = (state_q == RESP) && owner_q;

  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign alu_control = alu_control_q;
  assign alu_shamt   = alu_shamt_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt0_q;
  logic [31:0] grant_cnt1_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (r0_req_ready && (grant_cnt0_q != 32'hFFFF_FFFF)) begin
        grant_cnt0_q <= grant_cnt0_q + 32'd1;
      end
      if (r1_req_ready && (grant_cnt1_q != 32'hFFFF_FFFF)) begin
        grant_cnt1_q <= grant_cnt1_q + 32'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU sits on the alu_* ports,
// expected responses are queued at stimulus time and popped as responses appear.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic          owner;
    logic [W-1:0]  data;
    logic          zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
  logic [3:0]    r0_ctrl;
  logic [4:0]    r0_shamt;
  logic [W-1:0]  r0_a, r0_b;
  logic          r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
  logic [3:0]    r1_ctrl;
  logic [4:0]    r1_shamt;
  logic [W-1:0]  r1_a, r1_b;
  logic [W-1:0]  rsp_data;
  logic          rsp_zero;
  logic [3:0]    alu_control;
  logic [4:0]    alu_shamt;
  logic [W-1:0]  alu_a, alu_b, alu_out;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]   grant_cnt0, grant_cnt1;
`endif

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .r0_req_valid (r0_req_valid),
    .r0_req_ready (r0_req_ready),
    .r0_ctrl      (r0_ctrl),
    .r0_shamt     (r0_shamt),
    .r0_a         (r0_a),
    .r0_b         (r0_b),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_ready (r0_rsp_ready),
    .r1_req_valid (r1_req_valid),
    .r1_req_ready (r1_req_ready),
    .r1_ctrl      (r1_ctrl),
    .r1_shamt     (r1_shamt),
    .r1_a         (r1_a),
    .r1_b         (r1_b),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_ready (r1_rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_zero     (rsp_zero),
    .alu_control  (alu_control),
    .alu_shamt    (alu_shamt),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] aluModel(input logic [3:0] c, input logic [4:0] s,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      ADD, ADDU: return a + b;
      SUB, SUBU: return a - b;
      SLT:       return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:      return {{(W-1){1'b0}}, (a < b)};
      XOR:       return a ^ b;
      ORR:       return a | b;
      AND:       return a & b;
      SLL:       return a << s;
      SRL:       return a >> s;
      SRA:       return $signed(a) >>> s;
      default:   return '0;
    endcase
  endfunction

  // Behavioural stand-in for the shared ALU.
  always_comb alu_out = aluModel(alu_control, alu_shamt, alu_a, alu_b);

  task automatic driveReq(input logic who, input logic [3:0] c, input logic [4:0] s,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    if (who) begin
      r1_req_valid = 1'b1; r1_ctrl = c; r1_shamt = s; r1_a = a; r1_b = b;
    end else begin
      r0_req_valid = 1'b1; r0_ctrl = c; r0_shamt = s; r0_a = a; r0_b = b;
    end
  endtask

  task automatic clearReq(input logic who);
    if (who) r1_req_valid = 1'b0;
    else     r0_req_valid = 1'b0;
  endtask

  task automatic setRspReady(input logic who, input logic v);
    if (who) r1_rsp_ready = v;
    else     r0_rsp_ready = v;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one isolated transaction and returns what was observed; ok=0 on timeout.
  task automatic doTxn(input logic who, input logic [3:0] c, input logic [4:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit ok, output int lat, output logic [1:0] rv,
                       output logic [W-1:0] d, output logic z);
    int n;
    ok = 1'b0; lat = 0; rv = 2'b00; d = '0; z = 1'b0;
    @(negedge clk);
    driveReq(who, c, s, a, b);
    n = 0;
    #1;
    while (!(who ? r1_req_ready : r0_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!(who ? r1_req_ready : r0_req_ready)) begin
      clearReq(who);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    clearReq(who);
    lat = 1;
    #1;
    while (!(who ? r1_rsp_valid : r0_rsp_valid) && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    if (!(who ? r1_rsp_valid : r0_rsp_valid)) return;
    rv = {r1_rsp_valid, r0_rsp_valid};
    d  = rsp_data;
    z  = rsp_zero;
    setRspReady(who, 1'b1);
    @(posedge clk);
    @(negedge clk);
    setRspReady(who, 1'b0);
    ok = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    compared++; if (alu_control !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_ctrl: got %h expected 0", alu_control); end
    compared++; if (alu_a !== '0 || alu_b !== '0 || alu_shamt !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_operands: got a=%h b=%h sh=%h expected 0", alu_a, alu_b, alu_shamt); end
    compared++; if (rsp_data !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0", rsp_data); end
    compared++; if (rsp_zero !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_zero: got %b expected 1", rsp_zero); end
    compared++; if ({r1_rsp_valid, r0_rsp_valid, r1_req_ready, r0_req_ready} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_handshake: got %b expected 0000", {r1_rsp_valid, r0_rsp_valid, r1_req_ready, r0_req_ready}); end
    driveReq(1'b0, ADD, 5'd0, 32'd1, 32'd1);
    driveReq(1'b1, ADD, 5'd0, 32'd2, 32'd2);
    #1;
    compared++; if ({r1_req_ready, r0_req_ready} !== 2'b01) begin mismatched++; $display("[TB] FAIL reset_first_tie: got %b expected 01", {r1_req_ready, r0_req_ready}); end
    clearReq(1'b0); clearReq(1'b1);
  endtask

  task automatic test_single();
    bit ok; int lat; logic [1:0] rv; logic [W-1:0] d; logic z; exp_t e;
    sb.push_back('{1'b0, 32'd12, 1'b0});
    doTxn(1'b0, ADD, 5'd0, 32'd5, 32'd7, ok, lat, rv, d, z);
    e = sb.pop_front();
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL single_timeout: got ok=%b expected 1", ok); end
    compared++; if (lat !== 2) begin mismatched++; $display("[TB] FAIL single_latency: got %0d expected 2", lat); end
    compared++; if (rv !== {e.owner, ~e.owner}) begin mismatched++; $display("[TB] FAIL single_owner: got %b expected 01", rv); end
    compared++; if (d !== e.data) begin mismatched++; $display("[TB] FAIL single_data: got %h expected %h", d, e.data); end
    compared++; if (z !== e.zero) begin mismatched++; $display("[TB] FAIL single_zero: got %b expected %b", z, e.zero); end
  endtask

  task automatic test_alternate();
    logic [3:0] c0[2];
    logic [3:0] c1[2];
    logic [W-1:0] a0[2];
    logic [W-1:0] b0[2];
    logic [W-1:0] a1[2];
    logic [W-1:0] b1[2];
    int i0, i1, got, cycles;
    logic who;
    exp_t e;
    c0[0] = ADD; a0[0] = 32'd10;      b0[0] = 32'd20;
    c0[1] = XOR; a0[1] = 32'h0000_FF00; b0[1] = 32'h0000_0FF0;
    c1[0] = SUB; a1[0] = 32'd3;       b1[0] = 32'd3;
    c1[1] = SLT; a1[1] = 32'hFFFF_FFFF; b1[1] = 32'd1;
    applyReset();
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    i0 = 0; i1 = 0;
    driveReq(1'b0, c0[0], 5'd0, a0[0], b0[0]);
    driveReq(1'b1, c1[0], 5'd0, a1[0], b1[0]);
    sb.push_back('{1'b0, 32'd30, 1'b0});
    sb.push_back('{1'b1, 32'd0, 1'b1});
    sb.push_back('{1'b0, 32'h0000_F0F0, 1'b0});
    sb.push_back('{1'b1, 32'd1, 1'b0});
    got = 0; cycles = 0;
    while (got < 4 && cycles < 60) begin
      #1;
      if (r0_rsp_valid || r1_rsp_valid) begin
        e = sb.pop_front();
        who = r1_rsp_valid;
        compared++; if ({r1_rsp_valid, r0_rsp_valid} !== {e.owner, ~e.owner}) begin mismatched++; $display("[TB] FAIL alt_owner%0d: got %b expected owner %0d", got, {r1_rsp_valid, r0_rsp_valid}, e.owner); end
        compared++; if (rsp_data !== e.data) begin mismatched++; $display("[TB] FAIL alt_data%0d: got %h expected %h", got, rsp_data, e.data); end
        compared++; if (rsp_zero !== e.zero) begin mismatched++; $display("[TB] FAIL alt_zero%0d: got %b expected %b", got, rsp_zero, e.zero); end
        got++;
        if (who) begin
          i1++;
          if (i1 < 2) driveReq(1'b1, c1[i1], 5'd0, a1[i1], b1[i1]);
          else        clearReq(1'b1);
        end else begin
          i0++;
          if (i0 < 2) driveReq(1'b0, c0[i0], 5'd0, a0[i0], b0[i0]);
          else        clearReq(1'b0);
        end
      end
      @(negedge clk);
      cycles++;
    end
    compared++; if (got != 4) begin mismatched++; $display("[TB] FAIL alt_count: got %0d responses expected 4", got); end
    clearReq(1'b0); clearReq(1'b1);
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    sb.push_back('{1'b1, 32'd123, 1'b0});
    @(negedge clk);
    driveReq(1'b1, ADD, 5'd0, 32'd100, 32'd23);
    n = 0; #1;
    while (!r1_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    compared++; if (r1_req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_r1_grant: got %b expected 1", r1_req_ready); clearReq(1'b1); sb.delete(); return; end
    @(posedge clk);
    @(negedge clk);
    clearReq(1'b1);
    driveReq(1'b0, ORR, 5'd0, 32'h0000_00F0, 32'h0000_000F);
    sb.push_back('{1'b0, 32'h0000_00FF, 1'b0});
    r0_rsp_ready = 1'b1;
    n = 0; #1;
    while (!r1_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      compared++; if (rsp_data !== e.data) begin mismatched++; $display("[TB] FAIL bp_hold_data%0d: got %h expected %h", k, rsp_data, e.data); end
      compared++; if ({r1_rsp_valid, r0_rsp_valid, r0_req_ready} !== 3'b100) begin mismatched++; $display("[TB] FAIL bp_hold_hs%0d: got %b expected 100", k, {r1_rsp_valid, r0_rsp_valid, r0_req_ready}); end
      @(negedge clk); #1;
    end
    r1_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r1_rsp_ready = 1'b0;
    #1;
    compared++; if (r0_req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_r0_after_release: got %b expected 1", r0_req_ready); end
    @(posedge clk);
    @(negedge clk);
    clearReq(1'b0);
    n = 0; #1;
    while (!r0_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    e = sb.pop_front();
    compared++; if (r0_rsp_valid !== 1'b1 || rsp_data !== e.data) begin mismatched++; $display("[TB] FAIL bp_r0_result: got valid=%b data=%h expected 1/%h", r0_rsp_valid, rsp_data, e.data); end
    @(negedge clk);
    r0_rsp_ready = 1'b0;
  endtask

  task automatic test_shift_undef();
    bit ok; int lat; logic [1:0] rv; logic [W-1:0] d; logic z; exp_t e;
    sb.push_back('{1'b0, 32'hF800_0000, 1'b0});
    doTxn(1'b0, SRA, 5'd4, 32'h8000_0000, 32'd0, ok, lat, rv, d, z);
    e = sb.pop_front();
    compared++; if (!ok || rv !== 2'b01 || d !== e.data || z !== e.zero) begin mismatched++; $display("[TB] FAIL sra_result: got ok=%b rv=%b data=%h zero=%b expected 1/01/%h/%b", ok, rv, d, z, e.data, e.zero); end
    sb.push_back('{1'b1, aluModel(SLL, 5'd3, 32'h0000_0011, 32'd0), 1'b0});
    doTxn(1'b1, SLL, 5'd3, 32'h0000_0011, 32'd0, ok, lat, rv, d, z);
    e = sb.pop_front();
    compared++; if (!ok || rv !== 2'b10 || d !== e.data) begin mismatched++; $display("[TB] FAIL sll_result: got ok=%b rv=%b data=%h expected 1/10/%h", ok, rv, d, e.data); end
    sb.push_back('{1'b1, 32'd0, 1'b1});
    doTxn(1'b1, 4'hF, 5'd0, 32'd5, 32'd9, ok, lat, rv, d, z);
    e = sb.pop_front();
    compared++; if (!ok) begin mismatched++; $display("[TB] FAIL undef_delivered: got ok=%b expected 1", ok); end
    compared++; if (rv !== 2'b10 || d !== e.data || z !== e.zero) begin mismatched++; $display("[TB] FAIL undef_result: got rv=%b data=%h zero=%b expected 10/%h/%b", rv, d, z, e.data, e.zero); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; logic [1:0] rv; logic [W-1:0] d; logic z; int n;
    doTxn(1'b0, ADD, 5'd0, 32'd1, 32'd2, ok, lat, rv, d, z);
    compared++; if (!ok || d !== 32'd3) begin mismatched++; $display("[TB] FAIL rmid_pre: got ok=%b data=%h expected 1/3", ok, d); end
    @(negedge clk);
    driveReq(1'b1, SUB, 5'd1, 32'd9, 32'd4);
    n = 0; #1;
    while (!r1_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    clearReq(1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    driveReq(1'b0, ADD, 5'd0, 32'd1, 32'd1);
    driveReq(1'b1, ADD, 5'd0, 32'd2, 32'd2);
    #1;
    compared++; if (alu_control !== 4'd0 || alu_shamt !== 5'd0 || alu_a !== '0 || alu_b !== '0) begin mismatched++; $display("[TB] FAIL rmid_alu: got %h %h %h %h expected zeros", alu_control, alu_shamt, alu_a, alu_b); end
    compared++; if (rsp_data !== '0 || rsp_zero !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_rsp: got data=%h zero=%b expected 0/1", rsp_data, rsp_zero); end
    compared++; if ({r1_rsp_valid, r0_rsp_valid, r1_req_ready, r0_req_ready} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rmid_handshake: got %b expected 0000", {r1_rsp_valid, r0_rsp_valid, r1_req_ready, r0_req_ready}); end
    reset = 1'b0;
    #1;
    compared++; if ({r1_req_ready, r0_req_ready} !== 2'b01) begin mismatched++; $display("[TB] FAIL rmid_tie: got %b expected 01", {r1_req_ready, r0_req_ready}); end
    clearReq(1'b0); clearReq(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      compared++; if ({r1_rsp_valid, r0_rsp_valid} !== 2'b00) begin mismatched++; $display("[TB] FAIL rmid_no_rsp%0d: got %b expected 00", k, {r1_rsp_valid, r0_rsp_valid}); end
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    bit ok; int lat; logic [1:0] rv; logic [W-1:0] d; logic z;
    applyReset();
    #1;
    compared++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin mismatched++; $display("[TB] FAIL stats_init: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
    doTxn(1'b0, ADD, 5'd0, 32'd1, 32'd1, ok, lat, rv, d, z);
    doTxn(1'b1, ADD, 5'd0, 32'd2, 32'd1, ok, lat, rv, d, z);
    doTxn(1'b0, ADD, 5'd0, 32'd3, 32'd1, ok, lat, rv, d, z);
    doTxn(1'b1, ADD, 5'd0, 32'd4, 32'd1, ok, lat, rv, d, z);
    doTxn(1'b0, ADD, 5'd0, 32'd5, 32'd1, ok, lat, rv, d, z);
    #1;
    compared++; if (grant_cnt0 !== 32'd3 || grant_cnt1 !== 32'd2) begin mismatched++; $display("[TB] FAIL stats_count: got %0d/%0d expected 3/2", grant_cnt0, grant_cnt1); end
    applyReset();
    #1;
    compared++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin mismatched++; $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    r0_req_valid = 1'b0; r0_ctrl = 4'd0; r0_shamt = 5'd0; r0_a = '0; r0_b = '0; r0_rsp_ready = 1'b0;
    r1_req_valid = 1'b0; r1_ctrl = 4'd0; r1_shamt = 5'd0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_shift_undef();
    test_reset_mid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
